backlight_frame_scheduler: RTL
==============================

// Module: backlight_frame_scheduler
// PURPOSE
//  Sequences one local-dimming frame update into the backlight SRAM write port (sdbpflag/wtaddr/wtdina) feeding the SPI7001 driver path.
//  On each frame request: reads every zone luminance from the zone buffer, applies a global gain, then streams the results as addressed writes.
//  Sits between zone statistics (ramflag-style block) and sram_top, on the clk25M domain.
//  Reports frame requests that arrive while a frame is still in flight.
// PARAMETERS
//  ZONES      384  number of LED zones written per frame (1..2**ADDR_W)
//  ADDR_W     10   zone/SRAM address width
//  ZV_W       8    zone luminance width
//  DATA_W     16   SRAM write data width (must be >= ZV_W+8)
//  MIN_LEVEL  16   floor value used only when BFS_MINLEVEL_EN is defined
// PORTS
//  clk          in   1       single clock (clk25M domain)
//  reset_p      in   1       asynchronous reset, active high
//  frame_start  in   1       1-cycle pulse requesting a frame update, already synchronous to clk
//  gain         in   8       global brightness; effective multiplier is gain+1
//  zr_en        out  1       zone-buffer read strobe
//  zr_addr      out  ADDR_W  zone-buffer read address
//  zr_data      in   ZV_W    zone value, valid exactly 1 cycle after zr_en
//  sdbpflag     out  1       1-cycle frame-start marker to SRAM writer
//  wt_en        out  1       SRAM write strobe
//  wtaddr       out  ADDR_W  SRAM write address
//  wtdina       out  DATA_W  SRAM write data
//  busy         out  1       frame in progress
//  done         out  1       1-cycle pulse when the last write has been issued
//  overrun      out  1       sticky: frame_start seen while busy
//  overrun_clr  in   1       clears overrun (set wins over clear in the same cycle)
// BEHAVIOUR
//  Reset: all outputs 0; FSM -> IDLE; counters 0. Reset mid-frame aborts immediately; no partial completion or done pulse.
//  FSM: IDLE -> SOF -> RUN -> DRAIN -> DONE -> IDLE.
//   IDLE: frame_start=1 -> SOF; gain captured into gain_q (held constant for the whole frame).
//   SOF (1 cycle): sdbpflag=1, busy=1.
//   RUN (ZONES cycles): zr_en=1, zr_addr=0..ZONES-1, incrementing by one each cycle.
//   DRAIN (2 cycles): pipeline flush; no new reads issued.
//   DONE (1 cycle): done=1, busy=1; then IDLE.
//  Timing, with frame_start sampled in cycle 0:
//   sdbpflag in cycle 1. zr_en in cycles 2..ZONES+1. zr_data valid in cycles 3..ZONES+2.
//   wt_en/wtaddr/wtdina (registered) in cycles 4..ZONES+3. done in cycle ZONES+4.
//   busy is high in cycles 1..ZONES+4.
//  Write data: wtdina = zr_data * (gain_q+1), an exact unsigned product zero-extended to DATA_W (max 255*256 = 65280, no overflow).
//  wtaddr equals the zr_addr issued 2 cycles earlier; addresses are never skipped or repeated.
//  wtaddr/wtdina hold their last value when wt_en=0.
//  frame_start in any state other than IDLE (including DONE): request dropped, overrun set to 1 on the next edge.
//  Address counter stops at ZONES-1; it never wraps inside a frame.
// CONFIGURATION
//  BFS_MINLEVEL_EN defined: when zr_data!=0 and the product < MIN_LEVEL, wtdina=MIN_LEVEL. Zero input still writes 0. Latency unchanged.
//  BFS_MINLEVEL_EN undefined: wtdina is the raw product; MIN_LEVEL is ignored.
// TESTING (ZONES=8 unless noted)
//  1 Reset released, no stimulus -> all outputs 0 for 100 cycles.
//  2 frame_start at cycle 0, gain=255, zr_data=addr*16 ->
//    sdbpflag@1; writes @4..11 with wtaddr 0..7, wtdina = addr*4096; done@12; busy low @13.
//  3 gain=0, zr_data=8'hFF on all zones -> every wtdina=16'h00FF; gain changed mid-frame has no effect.
//  4 frame_start at cycle 6 and again at cycle 12 (DONE) -> both dropped, overrun=1;
//    overrun_clr -> 0; frame_start at cycle 13 is accepted.
//  5 reset_p pulsed at cycle 7 -> outputs 0 immediately, no done;
//    a new frame afterwards starts again from address 0.
//  6 BFS_MINLEVEL_EN defined, MIN_LEVEL=16, gain=0, zr_data={0,1,15,16,200} ->
//    wtdina={0,16,16,16,200}; undefined -> {0,1,15,16,200}.

Source files
------------

// File: rtl/backlight_frame_scheduler_if.sv
// Zone-buffer read port plus SRAM write port between the frame scheduler and its neighbours.
// The master side is the scheduler; the slave side is the zone buffer / SRAM writer.
interface backlight_frame_scheduler_if #(
  parameter int ADDR_W = 10,
  parameter int ZV_W   = 8,
  parameter int DATA_W = 16
);
  logic              zr_en;
  logic [ADDR_W-1:0] zr_addr;
  logic [ZV_W-1:0]   zr_data;
  logic              sdbpflag;
  logic              wt_en;
  logic [ADDR_W-1:0] wtaddr;
  logic [DATA_W-1:0] wtdina;

  modport master (
    output zr_en, zr_addr, sdbpflag, wt_en, wtaddr, wtdina,
    input  zr_data
  );

  modport slave (
    input  zr_en, zr_addr, sdbpflag, wt_en, wtaddr, wtdina,
    output zr_data
  );
endinterface

// File: rtl/backlight_frame_scheduler.sv
// Streams one gain-scaled zone frame into the backlight SRAM; first write 4 cycles after frame_start, done at ZONES+4.
// No backpressure: requests while busy are dropped and flagged on overrun. BFS_MINLEVEL_EN enables the non-zero floor.
module backlight_frame_scheduler #(
  parameter int ZONES     = 384,
  parameter int ADDR_W    = 10,
  parameter int ZV_W      = 8,
  parameter int DATA_W    = 16,
  parameter int MIN_LEVEL = 16
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       frame_start,
  input  logic [7:0] gain,
  backlight_frame_scheduler_if.master bus,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  input  logic       overrun_clr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ZONES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic              drain_cnt;
  logic [7:0]        gain_q;
  logic              rd_vld;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] prod;
  logic [DATA_W-1:0] wr_dat;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state        <= S_IDLE;
      drain_cnt    <= 1'b0;
      gain_q       <= '0;
      bus.sdbpflag <= 1'b0;
      bus.zr_en    <= 1'b0;
      bus.zr_addr  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      bus.sdbpflag <= 1'b0;
      done         <= 1'b0;

      // A request outside IDLE is lost; setting beats a simultaneous clear.
      if (frame_start && state != S_IDLE) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state        <= S_SOF;
            gain_q       <= gain;
            bus.sdbpflag <= 1'b1;
            busy         <= 1'b1;
          end
        end
        S_SOF: begin
          state       <= S_RUN;
          bus.zr_en   <= 1'b1;
          bus.zr_addr <= '0;
        end
        S_RUN: begin
          if (bus.zr_addr == LAST_ADDR) begin
            state     <= S_DRAIN;
            bus.zr_en <= 1'b0;
            drain_cnt <= 1'b0;
          end else begin
            bus.zr_addr <= bus.zr_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // gain+1 never exceeds 256, so the product fits DATA_W exactly.
  assign prod = DATA_W'(bus.zr_data) * DATA_W'({1'b0, gain_q} + 9'd1);

  always_comb begin
    wr_dat = prod;
`ifdef BFS_MINLEVEL_EN
    if (bus.zr_data != '0 && prod < DATA_W'(MIN_LEVEL)) begin
      wr_dat = DATA_W'(MIN_LEVEL);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      rd_vld     <= 1'b0;
      rd_addr    <= '0;
      bus.wt_en  <= 1'b0;
      bus.wtaddr <= '0;
      bus.wtdina <= '0;
    end else begin
      rd_vld    <= bus.zr_en;
      rd_addr   <= bus.zr_addr;
      bus.wt_en <= rd_vld;
      if (rd_vld) begin
        bus.wtaddr <= rd_addr;
        bus.wtdina <= wr_dat;
      end
    end
  end

endmodule
